shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU's single-position logical right shifter.
- Accepts an operand and a shift amount, then applies the one-bit shift once per clock until the amount is exhausted.
- Reports the final result with zero and carry flags through a start/ready/done handshake.
- Sits between the lab ALU operation decoder and the shift datapath, so multi-bit SHR executes on the 1-bit shift hardware.

Parameters:
- WIDTH, 4, operand/result width in bits.
- AMT_W, 3, shift-amount width in bits; must satisfy 2**AMT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while ready=1.
- a  input  WIDTH  operand; latched when start is accepted.
- amt  input  AMT_W  shift amount; latched when start is accepted.
- ready  output  1  high in IDLE and DONE states (new start accepted).
- busy  output  1  high in SHIFT state.
- done  output  1  one-cycle pulse when result and flags become valid.
- result  output  WIDTH  shifted operand; held until the next accepted start.
- zero_flag  output  1  high when result == 0; held with result.
- carry_flag  output  1  last bit shifted out (0 if no shift performed); held with result.

Behaviour:
- Reset: clk and rst are the only clock/reset. rst=1 at a rising edge forces:
  - state=IDLE
  - result=0, carry_flag=0, zero_flag=0, done=0, count=0
  - ready=1, busy=0
- Reset applied mid-SHIFT aborts the operation and produces no done pulse.
- States:
  - IDLE: ready=1. start=1 → latch a into the working register, clear carry, load count=amt_eff. Next state is SHIFT if amt_eff>0, else DONE.
  - SHIFT: busy=1, ready=0. Each edge: reg <= {1'b0, reg[WIDTH-1:1]}, carry <= reg[0], count <= count-1. When count==1 at the edge, next state is DONE. start is ignored in this state.
  - DONE: done=1 for exactly one cycle; result = reg, zero_flag = (reg==0), carry_flag = carry; ready=1. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise next state is IDLE.
- Clamping: amt_eff = min(amt, WIDTH). Amounts above WIDTH yield result=0 and carry = a[WIDTH-1], the same as a shift by WIDTH.
- Latency: done is asserted amt_eff+1 rising edges after the edge that accepted start.
  - amt=0 gives done on the next cycle, result=a, carry_flag=0.
- Output holding:
  - result and flags update only in DONE and hold through IDLE.
  - On a new accepted start they retain their old values until the new DONE.
- Fill and ordering:
  - Zero fill from the MSB; no arithmetic or rotate mode.
  - Carry always reflects the most recent shift step only.
- Start and rst in the same cycle: rst wins.

Decomposition:
- Package shift_seq_pkg:
  - state enum seq_state_t {IDLE, SHIFT, DONE}.
  - Default WIDTH/AMT_W localparams.
- Sub-module shr1_unit: parameterized WIDTH single-step combinational logical right shift.
  - Outputs: shifted value and shifted-out bit.
  - Instantiated once inside the sequencer.
- Controller: FSM, count register and clamp logic stay in shift_seq_ctrl.

Test Plan:
- a=4'b1011, amt=2, start one cycle → busy for 2 cycles; done on 3rd edge after accept; result=4'b0010, carry_flag=1, zero_flag=0.
- a=4'b1000, amt=0 → done on next edge; result=4'b1000, carry_flag=0, zero_flag=0; busy never asserted.
- a=4'b0001, amt=1 → done after 2 edges; result=4'b0000, carry_flag=1, zero_flag=1.
- a=4'b1111, amt=6 (clamped to 4) → done after 5 edges; result=0, carry_flag=1, zero_flag=1.
- Start a=4'b0110, amt=3, then pulse start with a=4'b1111 during SHIFT → ignored; result=4'b0000, carry_flag=1, zero_flag=1. Then start a=4'b1010, amt=1 in the DONE cycle → accepted; next done gives result=4'b0101, carry_flag=0.
- Start a=4'b1100, amt=4, assert rst during 2nd SHIFT cycle → next cycle state IDLE, ready=1, result=0, flags=0, no done pulse.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and default sizing for the multi-cycle logical right-shift sequencer.
package shift_seq_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultAmtW  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Start/ready/done handshake between the ALU op decoder and the shift sequencer.
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;

  modport master (
    output start,
    output a,
    output amt,
    input  ready,
    input  busy,
    input  done,
    input  result,
    input  zero_flag,
    input  carry_flag
  );

  modport slave (
    input  start,
    input  a,
    input  amt,
    output ready,
    output busy,
    output done,
    output result,
    output zero_flag,
    output carry_flag
  );

endinterface

// File: rtl/shr1_unit.sv
// Single-step logical right shift: zero fill from the MSB, LSB reported as the shifted-out bit.
module shr1_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             bit_out
);

  always_comb begin
    dout    = {1'b0, din[WIDTH-1:1]};
    bit_out = din[0];
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that executes a multi-bit SHR by stepping the one-bit shifter once per clock,
// then presents the result with zero/carry flags for a single done cycle.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned AMT_W = DefaultAmtW
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus
);

  localparam logic [AMT_W-1:0] WidthAmt = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] OneAmt   = AMT_W'(1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cflag_q, cflag_d;

  logic [WIDTH-1:0] shifted;
  logic             shift_out;
  logic [AMT_W-1:0] amt_eff;
  logic             ready;
  logic             accept;

  shr1_unit #(
    .WIDTH (WIDTH)
  ) u_shr1 (
    .din     (work_q),
    .dout    (shifted),
    .bit_out (shift_out)
  );

  // Amounts past WIDTH behave exactly like a full-width shift.
  always_comb begin
    amt_eff = (bus.amt > WidthAmt) ? WidthAmt : bus.amt;
  end

  always_comb begin
    ready  = (state_q == IDLE) || (state_q == DONE);
    accept = ready && bus.start;
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    carry_d  = carry_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    cflag_d  = cflag_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        work_d  = shifted;
        carry_d = shift_out;
        count_d = count_q - OneAmt;
        if (count_q == OneAmt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = work_q;
        zero_d   = (work_q == '0);
        cflag_d  = carry_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance in IDLE or DONE overrides the default path so back-to-back starts chain.
    if (accept) begin
      work_d  = bus.a;
      carry_d = 1'b0;
      count_d = amt_eff;
      state_d = (amt_eff != '0) ? SHIFT : DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cflag_q  <= cflag_d;
    end
  end

  // During DONE the live working values are shown; otherwise the last captured ones hold.
  always_comb begin
    bus.ready      = ready;
    bus.busy       = (state_q == SHIFT);
    bus.done       = (state_q == DONE);
    bus.result     = (state_q == DONE) ? work_q : result_q;
    bus.zero_flag  = (state_q == DONE) ? (work_q == '0) : zero_q;
    bus.carry_flag = (state_q == DONE) ? carry_q : cflag_q;
  end

  shift_count_nonzero_a : assert property (
    @(posedge clk) disable iff (rst) (state_q == SHIFT) |-> (count_q != '0)
  );

  ready_busy_exclusive_a : assert property (
    @(posedge clk) disable iff (rst) !(bus.ready && bus.busy)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with hand-computed results, latencies and flags.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shift_seq_ctrl_if #(.WIDTH(4), .AMT_W(3)) bus ();

  shift_seq_ctrl #(
    .WIDTH (4),
    .AMT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; returns sampled 1ns after the accepting edge.
  task automatic launch(input logic [3:0] a, input logic [2:0] amt);
    bus.start = 1'b1;
    bus.a     = a;
    bus.amt   = amt;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts further edges until done; ends in the done cycle.
  task automatic wait_done(input string tag, input int exp_lat, input logic [3:0] exp_res,
                           input logic exp_c, input logic exp_z);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 8'(n), 8'(exp_lat));
    check_eq({tag, "_busy"}, 8'(busy_cnt), 8'(exp_lat));
    check_eq({tag, "_res"}, 8'(bus.result), 8'(exp_res));
    check_eq({tag, "_carry"}, 8'(bus.carry_flag), 8'(exp_c));
    check_eq({tag, "_zero"}, 8'(bus.zero_flag), 8'(exp_z));
    check_eq({tag, "_ready"}, 8'(bus.ready), 8'h1);
  endtask

  initial begin
    int seen_done;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.amt   = '0;
    tick();
    tick();
    check_eq("rst_ready", 8'(bus.ready), 8'h1);
    check_eq("rst_busy", 8'(bus.busy), 8'h0);
    check_eq("rst_done", 8'(bus.done), 8'h0);
    check_eq("rst_res", 8'(bus.result), 8'h0);
    check_eq("rst_flags", 8'({bus.zero_flag, bus.carry_flag}), 8'h0);
    rst = 1'b0;
    tick();

    launch(4'b1011, 3'd2);
    wait_done("t1", 2, 4'b0010, 1'b1, 1'b0);
    tick();
    check_eq("t1_pulse", 8'(bus.done), 8'h0);
    check_eq("t1_hold", 8'(bus.result), 8'b0010);
    check_eq("t1_hold_c", 8'(bus.carry_flag), 8'h1);

    launch(4'b1000, 3'd0);
    wait_done("t2", 0, 4'b1000, 1'b0, 1'b0);
    tick();

    launch(4'b0001, 3'd1);
    check_eq("t3_hold_busy", 8'(bus.result), 8'b1000);
    wait_done("t3", 1, 4'b0000, 1'b1, 1'b1);
    tick();

    launch(4'b1111, 3'd6);
    wait_done("t4", 4, 4'b0000, 1'b1, 1'b1);
    tick();

    // Clamp boundary: carry is a[3]=0 for a full-width shift.
    launch(4'b0111, 3'd7);
    wait_done("t4b", 4, 4'b0000, 1'b0, 1'b1);
    tick();

    launch(4'b1011, 3'd3);
    wait_done("t4c", 3, 4'b0001, 1'b0, 1'b0);
    tick();

    // Start during SHIFT must be ignored.
    launch(4'b0110, 3'd3);
    tick();
    check_eq("t5_busy", 8'(bus.busy), 8'h1);
    bus.start = 1'b1;
    bus.a     = 4'b1111;
    bus.amt   = 3'd0;
    #1;
    check_eq("t5_notready", 8'(bus.ready), 8'h0);
    tick();
    bus.start = 1'b0;
    wait_done("t5", 1, 4'b0000, 1'b1, 1'b1);
    launch(4'b1010, 3'd1);
    check_eq("t5b_hold", 8'(bus.result), 8'b0000);
    wait_done("t5b", 1, 4'b0101, 1'b0, 1'b0);
    tick();

    // Reset in the second SHIFT cycle aborts without a done pulse.
    launch(4'b1100, 3'd4);
    tick();
    check_eq("t6_busy", 8'(bus.busy), 8'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_ready", 8'(bus.ready), 8'h1);
    check_eq("t6_busy0", 8'(bus.busy), 8'h0);
    check_eq("t6_res", 8'(bus.result), 8'h0);
    check_eq("t6_flags", 8'({bus.zero_flag, bus.carry_flag}), 8'h0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) seen_done = 1;
      tick();
    end
    check_eq("t6_nodone", 8'(seen_done), 8'h0);

    // Start and reset together: reset wins.
    bus.start = 1'b1;
    bus.a     = 4'b1111;
    bus.amt   = 3'd0;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check_eq("t7_done", 8'(bus.done), 8'h0);
    check_eq("t7_ready", 8'(bus.ready), 8'h1);
    tick();
    check_eq("t7_done2", 8'(bus.done), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
